// File: rtl/pe_pkg.sv
// Shared encodings and sizes for the pe_core processing element and its compute units.
// Also hosts the pairwise adder-tree reduction used by the top level.
package pe_pkg;

  localparam int LANES = 16;
  localparam int DW    = 32;

  typedef enum logic [1:0] {
    CU_HOLD = 2'b00,
    CU_SUB  = 2'b01,
    CU_ADD  = 2'b10,
    CU_MUL  = 2'b11
  } cu_op_e;

  typedef enum logic [1:0] {
    GB_NONE   = 2'b00,
    GB_SAVE_B = 2'b01,
    GB_FWD    = 2'b10,
    GB_SAVE_A = 2'b11
  } go_back_e;

  typedef enum logic [1:0] {
    AS_HOLD  = 2'b00,
    AS_LANES = 2'b01,
    AS_TREE  = 2'b10,
    AS_BOTH  = 2'b11
  } adder_sel_e;

  // Balanced pairwise reduction; in-place is safe because each level only reads indices >= i.
  function automatic logic [DW-1:0] adder_tree(input logic [LANES-1:0][DW-1:0] v);
    logic [LANES-1:0][DW-1:0] acc;
    acc = v;
    for (int w = LANES / 2; w >= 1; w = w / 2) begin
      for (int i = 0; i < w; i++) begin
        acc[i] = acc[2*i] + acc[2*i+1];
      end
    end
    return acc[0];
  endfunction

endpackage

// File: rtl/pe_cu.sv
// One compute lane: operand registers with sticky feedback binds, the CU, save and forward registers.
// Optional macro PE_SUB_EN builds the subtractor; without it Sel_cu 01 holds cu_out.
module pe_cu
  import pe_pkg::*;
(
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic [DW-1:0] a_i,
  input  logic [DW-1:0] b_i,
  input  logic [1:0]    sel_cu_i,
  input  logic [1:0]    sel_go_back_i,
  input  logic          save_en_i,
  output logic [DW-1:0] fwd_o
);

  logic [DW-1:0] op_a_q, op_a_d, op_b_q, op_b_d;
  logic [DW-1:0] cu_q, cu_d, save_q, save_d, fwd_q, fwd_d;
  logic          bind_a_q, bind_a_d, bind_b_q, bind_b_d;
  logic          idle, binding_now;

  always_comb begin
    idle        = (sel_cu_i == CU_HOLD) && (sel_go_back_i == GB_NONE);
    binding_now = (sel_go_back_i == GB_SAVE_A) || (sel_go_back_i == GB_SAVE_B);

    bind_a_d = idle ? 1'b0 : ((sel_go_back_i == GB_SAVE_A) ? 1'b1 : bind_a_q);
    bind_b_d = idle ? 1'b0 : ((sel_go_back_i == GB_SAVE_B) ? 1'b1 : bind_b_q);

    op_a_d = (sel_go_back_i == GB_SAVE_A) ? save_q : (bind_a_q ? op_a_q : a_i);
    op_b_d = (sel_go_back_i == GB_SAVE_B) ? save_q : (bind_b_q ? op_b_q : b_i);

    cu_d = cu_q;
    case (sel_cu_i)
`ifdef PE_SUB_EN
      CU_SUB:  cu_d = op_a_q - op_b_q;
`endif
      CU_ADD:  cu_d = op_a_q + op_b_q;
      CU_MUL:  cu_d = op_a_q * op_b_q;
      default: cu_d = cu_q;
    endcase

    // Save freezes once either operand is bound, including a bind requested this cycle.
    save_d = (save_en_i && !bind_a_q && !bind_b_q && !binding_now) ? cu_q : save_q;
    fwd_d  = (sel_go_back_i == GB_FWD) ? cu_q : fwd_q;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      op_a_q   <= '0;
      op_b_q   <= '0;
      bind_a_q <= 1'b0;
      bind_b_q <= 1'b0;
      cu_q     <= '0;
      save_q   <= '0;
      fwd_q    <= '0;
    end else begin
      op_a_q   <= op_a_d;
      op_b_q   <= op_b_d;
      bind_a_q <= bind_a_d;
      bind_b_q <= bind_b_d;
      cu_q     <= cu_d;
      save_q   <= save_d;
      fwd_q    <= fwd_d;
    end
  end

  assign fwd_o = fwd_q;

endmodule

// File: rtl/pe_core.sv
// Processing element top: 16 pe_cu lanes, adder tree over the forwarded results, output registers.
// Subtract support follows PE_SUB_EN inside pe_cu.
module pe_core
  import pe_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] In0, In1, In2, In3, In4, In5, In6, In7,
  input  logic [DW-1:0] In8, In9, In10, In11, In12, In13, In14, In15,
  input  logic [DW-1:0] Par0, Par1, Par2, Par3, Par4, Par5, Par6, Par7,
  input  logic [DW-1:0] Par8, Par9, Par10, Par11, Par12, Par13, Par14, Par15,
  input  logic [1:0]    Sel_cu,
  input  logic [1:0]    Sel_cu_go_back,
  input  logic [1:0]    Sel_adder,
  input  logic          Is_save_cu_out,
  output logic [DW-1:0] Out_total,
  output logic [DW-1:0] Out0, Out1, Out2, Out3, Out4, Out5, Out6, Out7,
  output logic [DW-1:0] Out8, Out9, Out10, Out11, Out12, Out13, Out14, Out15
);

  logic [LANES-1:0][DW-1:0] in_vec, par_vec, fwd_vec, out_q, out_d;
  logic [DW-1:0]            total_q, total_d, tree_sum;

  assign in_vec  = {In15, In14, In13, In12, In11, In10, In9, In8,
                    In7, In6, In5, In4, In3, In2, In1, In0};
  assign par_vec = {Par15, Par14, Par13, Par12, Par11, Par10, Par9, Par8,
                    Par7, Par6, Par5, Par4, Par3, Par2, Par1, Par0};

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    pe_cu u_cu (
      .clk_i         (clk),
      .rst_ni        (rst),
      .a_i           (in_vec[g]),
      .b_i           (par_vec[g]),
      .sel_cu_i      (Sel_cu),
      .sel_go_back_i (Sel_cu_go_back),
      .save_en_i     (Is_save_cu_out),
      .fwd_o         (fwd_vec[g])
    );
  end

  assign tree_sum = adder_tree(fwd_vec);

  // Bit 0 of Sel_adder refreshes the lane outputs, bit 1 the tree total.
  always_comb begin
    out_d   = out_q;
    total_d = total_q;
    if (Sel_adder[0]) out_d   = fwd_vec;
    if (Sel_adder[1]) total_d = tree_sum;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      out_q   <= '0;
      total_q <= '0;
    end else begin
      out_q   <= out_d;
      total_q <= total_d;
    end
  end

  assign Out_total = total_q;
  assign {Out15, Out14, Out13, Out12, Out11, Out10, Out9, Out8,
          Out7, Out6, Out5, Out4, Out3, Out2, Out1, Out0} = out_q;

endmodule

// File: tb/tb_pe_core.sv
// Directed self-checking bench for pe_core: dot product, element-wise, distance, wrap, subtract, reset.
// Expected values are hand-computed constants; PE_SUB_EN selects the subtract expectation.
module tb_pe_core;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] inA [16];
  logic [31:0] parB [16];
  logic [1:0]  selCu, selGoBack, selAdder;
  logic        isSave;
  logic [31:0] outTotal;
  logic [31:0] outLane [16];
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  pe_core dut (
    .clk(clk), .rst(rst),
    .In0(inA[0]), .In1(inA[1]), .In2(inA[2]), .In3(inA[3]),
    .In4(inA[4]), .In5(inA[5]), .In6(inA[6]), .In7(inA[7]),
    .In8(inA[8]), .In9(inA[9]), .In10(inA[10]), .In11(inA[11]),
    .In12(inA[12]), .In13(inA[13]), .In14(inA[14]), .In15(inA[15]),
    .Par0(parB[0]), .Par1(parB[1]), .Par2(parB[2]), .Par3(parB[3]),
    .Par4(parB[4]), .Par5(parB[5]), .Par6(parB[6]), .Par7(parB[7]),
    .Par8(parB[8]), .Par9(parB[9]), .Par10(parB[10]), .Par11(parB[11]),
    .Par12(parB[12]), .Par13(parB[13]), .Par14(parB[14]), .Par15(parB[15]),
    .Sel_cu(selCu), .Sel_cu_go_back(selGoBack), .Sel_adder(selAdder),
    .Is_save_cu_out(isSave), .Out_total(outTotal),
    .Out0(outLane[0]), .Out1(outLane[1]), .Out2(outLane[2]), .Out3(outLane[3]),
    .Out4(outLane[4]), .Out5(outLane[5]), .Out6(outLane[6]), .Out7(outLane[7]),
    .Out8(outLane[8]), .Out9(outLane[9]), .Out10(outLane[10]), .Out11(outLane[11]),
    .Out12(outLane[12]), .Out13(outLane[13]), .Out14(outLane[14]), .Out15(outLane[15])
  );

  task automatic applyStimulus(input logic [1:0] cu, input logic [1:0] gb,
                               input logic [1:0] ad, input logic sv);
    selCu     = cu;
    selGoBack = gb;
    selAdder  = ad;
    isSave    = sv;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clearBinds();
    applyStimulus(2'b00, 2'b00, 2'b00, 1'b0);
    step(1);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      inA[i]  = 32'hDEAD0000 + i;
      parB[i] = 32'h0000BEEF;
    end
    applyStimulus(2'b11, 2'b10, 2'b11, 1'b1);
    step(3);
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (outLane[i] !== 32'h0) begin
        errors++;
        $display("[TB] FAIL reset_out%0d: got %h expected 00000000", i, outLane[i]);
      end
    end
    checks++;
    if (outTotal !== 32'h0) begin
      errors++;
      $display("[TB] FAIL reset_total: got %h expected 00000000", outTotal);
    end
    rst = 1'b1;
    clearBinds();
  endtask

  task automatic test_dot_product();
    for (int i = 0; i < 16; i++) begin
      inA[i]  = 32'd1;
      parB[i] = 32'(i + 1);
    end
    applyStimulus(2'b11, 2'b10, 2'b10, 1'b0);
    step(4);
    checks++;
    if (outTotal !== 32'h88) begin
      errors++;
      $display("[TB] FAIL dot_total: got %h expected 00000088", outTotal);
    end
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (outLane[i] !== 32'h0) begin
        errors++;
        $display("[TB] FAIL dot_out%0d_held: got %h expected 00000000", i, outLane[i]);
      end
    end
    clearBinds();
  endtask

  task automatic test_elementwise();
    for (int i = 0; i < 16; i++) begin
      inA[i]  = 32'(i + 1);
      parB[i] = 32'd2;
    end
    applyStimulus(2'b11, 2'b10, 2'b01, 1'b0);
    step(4);
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (outLane[i] !== 32'(2 * (i + 1))) begin
        errors++;
        $display("[TB] FAIL elem_out%0d: got %h expected %h", i, outLane[i], 32'(2 * (i + 1)));
      end
    end
    checks++;
    if (outTotal !== 32'h88) begin
      errors++;
      $display("[TB] FAIL elem_total_held: got %h expected 00000088", outTotal);
    end
    clearBinds();
  endtask

  task automatic test_distance();
    for (int i = 0; i < 16; i++) begin
      inA[i]  = 32'd1;
      parB[i] = 32'(i + 1);
    end
    applyStimulus(2'b10, 2'b00, 2'b00, 1'b0);
    step(2);
    applyStimulus(2'b10, 2'b00, 2'b00, 1'b1);
    step(1);
    applyStimulus(2'b10, 2'b01, 2'b00, 1'b0);
    step(1);
    applyStimulus(2'b10, 2'b11, 2'b00, 1'b0);
    step(1);
    applyStimulus(2'b11, 2'b00, 2'b00, 1'b0);
    step(1);
    applyStimulus(2'b11, 2'b10, 2'b00, 1'b0);
    step(1);
    applyStimulus(2'b11, 2'b10, 2'b10, 1'b0);
    step(1);
    checks++;
    if (outTotal !== 32'h6F8) begin
      errors++;
      $display("[TB] FAIL dist_total: got %h expected 000006f8", outTotal);
    end
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (outLane[i] !== 32'(2 * (i + 1))) begin
        errors++;
        $display("[TB] FAIL dist_out%0d_held: got %h expected %h", i, outLane[i], 32'(2 * (i + 1)));
      end
    end
    clearBinds();
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 16; i++) begin
      inA[i]  = 32'h0;
      parB[i] = 32'h0;
    end
    inA[0]  = 32'hFFFFFFFF;
    parB[0] = 32'd2;
    applyStimulus(2'b11, 2'b10, 2'b11, 1'b0);
    step(4);
    checks++;
    if (outLane[0] !== 32'hFFFFFFFE) begin
      errors++;
      $display("[TB] FAIL wrap_mul_out0: got %h expected fffffffe", outLane[0]);
    end
    checks++;
    if (outTotal !== 32'hFFFFFFFE) begin
      errors++;
      $display("[TB] FAIL wrap_mul_total: got %h expected fffffffe", outTotal);
    end
    applyStimulus(2'b10, 2'b10, 2'b11, 1'b0);
    step(4);
    checks++;
    if (outLane[0] !== 32'h1) begin
      errors++;
      $display("[TB] FAIL wrap_add_out0: got %h expected 00000001", outLane[0]);
    end
    checks++;
    if (outTotal !== 32'h1) begin
      errors++;
      $display("[TB] FAIL wrap_add_total: got %h expected 00000001", outTotal);
    end
    for (int i = 0; i < 16; i++) inA[i] = 32'h80000000;
    parB[0] = 32'h0;
    step(4);
    checks++;
    if (outLane[7] !== 32'h80000000) begin
      errors++;
      $display("[TB] FAIL tree_wrap_out7: got %h expected 80000000", outLane[7]);
    end
    checks++;
    if (outTotal !== 32'h0) begin
      errors++;
      $display("[TB] FAIL tree_wrap_total: got %h expected 00000000", outTotal);
    end
    clearBinds();
  endtask

  task automatic test_sub();
    logic [31:0] expSub;
`ifdef PE_SUB_EN
    expSub = 32'hFFFFFFFE;
`else
    expSub = 32'd35;
`endif
    for (int i = 0; i < 16; i++) begin
      inA[i]  = 32'd5;
      parB[i] = 32'd7;
    end
    applyStimulus(2'b11, 2'b10, 2'b01, 1'b0);
    step(4);
    checks++;
    if (outLane[3] !== 32'd35) begin
      errors++;
      $display("[TB] FAIL sub_pre_mul_out3: got %h expected 00000023", outLane[3]);
    end
    applyStimulus(2'b01, 2'b10, 2'b01, 1'b0);
    step(4);
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (outLane[i] !== expSub) begin
        errors++;
        $display("[TB] FAIL sub_out%0d: got %h expected %h", i, outLane[i], expSub);
      end
    end
    clearBinds();
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 16; i++) begin
      inA[i]  = 32'd3;
      parB[i] = 32'd4;
    end
    applyStimulus(2'b10, 2'b11, 2'b11, 1'b0);
    step(2);
    rst = 1'b0;
    step(1);
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (outLane[i] !== 32'h0) begin
        errors++;
        $display("[TB] FAIL midreset_out%0d: got %h expected 00000000", i, outLane[i]);
      end
    end
    checks++;
    if (outTotal !== 32'h0) begin
      errors++;
      $display("[TB] FAIL midreset_total: got %h expected 00000000", outTotal);
    end
    rst = 1'b1;
    for (int i = 0; i < 16; i++) begin
      inA[i]  = 32'd1;
      parB[i] = 32'(i + 1);
    end
    applyStimulus(2'b11, 2'b10, 2'b10, 1'b0);
    step(4);
    checks++;
    if (outTotal !== 32'h88) begin
      errors++;
      $display("[TB] FAIL midreset_binds_cleared_total: got %h expected 00000088", outTotal);
    end
  endtask

  initial begin
    test_reset();
    test_dot_product();
    test_elementwise();
    test_distance();
    test_wrap();
    test_sub();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pe_core.md
# pe_core

Processing element of the accelerator datapath: 16 parallel 32-bit compute units (CUs), per-lane result feedback into the operand path, and a 16-input adder tree. It serves dot products (LR/SVM/DNN), element-wise products, and distance kernels (add/sub then square-and-sum; k-NN/k-Means). It sits between the operand/parameter buffers and the result writeback. Driven by a static control word from the accelerator controller.

## Interface
- No parameters. Lane count 16 and data width 32 are fixed.
- clk  in  1  sole clock, rising edge.
- rst  in  1  reset, synchronous, active-low.
- In0..In15  in  32 each  lane A operands (input data).
- Par0..Par15  in  32 each  lane B operands (parameters).
- Sel_cu  in  2  CU op: 00 hold, 01 sub (A−B), 10 add (A+B), 11 mul (A·B).
- Sel_cu_go_back  in  2  00 none, 01 save→B, 11 save→A, 10 forward cu_out to output stage.
- Sel_adder  in  2  00 hold, 01 bypass lanes to Out0..15, 10 adder tree to Out_total, 11 both.
- Is_save_cu_out  in  1  capture cu_out into per-lane save register.
- Out_total  out  32  adder-tree sum.
- Out0..Out15  out  32 each  per-lane results.

## Operation
- Per lane registers: opA, opB, bindA, bindB, cu_out, save, fwd; plus Out_i, Out_total.
- opA <= bindA ? opA : In_i; opB <= bindB ? opB : Par_i.
- go_back 01: opB <= save, bindB <= 1. go_back 11: opA <= save, bindA <= 1. Binds are sticky.
- Binds clear when Sel_cu==00 and Sel_cu_go_back==00 (idle control word).
- cu_out <= op(opA,opB) per Sel_cu; 00 holds cu_out.
- Arithmetic unsigned, modulo 2^32; mul keeps low 32 bits; sub wraps.
- save <= cu_out when Is_save_cu_out==1 and bindA==bindB==0; otherwise holds. Save therefore freezes once feedback begins.
- go_back 10: fwd <= cu_out; otherwise fwd holds.
- Sel_adder bit0: Out_i <= fwd_i. Sel_adder bit1: Out_total <= Σ fwd_0..15 (mod 2^32). A cleared bit holds the corresponding outputs.
- X/unknown control values are not supported. The controller drives all selects after reset.

## Timing
- Reset: every register and output is 0, including binds.
- Pipeline: inputs → opA/opB (1) → cu_out (2) → fwd (3) → Out_i/Out_total (4).
- A static control word yields valid outputs 4 cycles after inputs are stable.
- Feedback: save→op takes 1 cycle. The new cu_out appears the following cycle.
- Simultaneous Is_save and bind in the same cycle: bind wins (save does not update).
- Reset mid-operation drops all state on that edge.
- Adder tree is single-cycle combinational, registered into Out_total.

## Configuration
- PE_SUB_EN defined: Sel_cu 01 performs A−B.
- PE_SUB_EN undefined: Sel_cu 01 behaves as 00 (hold) and no subtractor is built.

## Structure
- Package pe_pkg holds:
  - CU op encodings
  - go_back encodings
  - adder-select encodings
  - LANES=16, DW=32
- Sub-module pe_cu, instantiated 16×, holds opA/opB/bind/cu_out/save/fwd.
- Top level holds the adder tree and output registers.

## Test plan
- Dot product: In_i=1, Par_i=i+1; Sel_cu=11, then go_back=10, then Sel_adder=10 → Out_total=0x88 (136).
- Element-wise: In_i=i+1, Par_i=2; Sel_cu=11, go_back=10, Sel_adder=01 → Out_i=2(i+1); Out_total holds its prior value.
- Distance: In_i=1, Par_i=i+1; Sel_cu=10; Is_save=1; go_back=01; go_back=11; Sel_cu=11; go_back=10; Sel_adder=10 → Out_total=0x6F8 (Σ(i+2)²=1784).
- Wrap: In0=0xFFFFFFFF, Par0=2, mul → Out0=0xFFFFFFFE; add → 0x00000001.
- Reset: assert rst=0 mid-sequence → all outputs 0 next edge; binds cleared.
- With PE_SUB_EN: In_i=5, Par_i=7, Sel_cu=01 → Out_i=0xFFFFFFFE. Without PE_SUB_EN, the same stimulus leaves cu_out held.
